imm_ext_pipe: RTL and testbench



---
 rtl/imm_ext_pipe_if.sv | 28 ++
 rtl/imm_ext_pipe.sv | 115 +++++++++++
 tb/tb_imm_ext_pipe.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle between the decode stage, the immediate extender and its consumer.
// The master drives instruction words in and accepts immediates out; the slave is the extender.
interface imm_ext_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [2:0]        in_fmt;
   logic              in_unsigned;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_imm;
   logic [TAG_W-1:0]  out_tag;
   logic              out_fmt_err;

   modport master (
      output in_valid, in_instr, in_fmt, in_unsigned, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_tag, out_fmt_err
   );

   modport slave (
      input  in_valid, in_instr, in_fmt, in_unsigned, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_tag, out_fmt_err
   );
endinterface

// File: rtl/imm_ext_pipe.sv
// RISC-V immediate generator/extender feeding a 2-entry skid buffer.
// The immediate is built at the input and stored, so outputs come straight from registers.
module imm_ext_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   imm_ext_pipe_if.slave bus
);

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
      logic             fmtErr;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } count_e;

   localparam logic [2:0] FMT_I     = 3'd0;
   localparam logic [2:0] FMT_S     = 3'd1;
   localparam logic [2:0] FMT_B     = 3'd2;
   localparam logic [2:0] FMT_U     = 3'd3;
   localparam logic [2:0] FMT_J     = 3'd4;
   localparam logic [2:0] FMT_RAW16 = 3'd5;

   entry_t head_q, head_d;
   entry_t tail_q, tail_d;
   count_e count_q, count_d;
   entry_t newEntry;
   logic   extBit;
   logic   push;
   logic   pop;

   // Fill the whole word with the extension bit, then overlay the raw field.
   always_comb begin
      extBit = ~bus.in_unsigned &
               ((bus.in_fmt == FMT_RAW16) ? bus.in_instr[15] : bus.in_instr[31]);
      newEntry.imm    = {XLEN{extBit}};
      newEntry.tag    = bus.in_tag;
      newEntry.fmtErr = 1'b0;
      unique case (bus.in_fmt)
         FMT_I: newEntry.imm[11:0] = bus.in_instr[31:20];
         FMT_S: newEntry.imm[11:0] = {bus.in_instr[31:25], bus.in_instr[11:7]};
         FMT_B: newEntry.imm[12:0] = {bus.in_instr[31], bus.in_instr[7],
                                      bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
         FMT_U: newEntry.imm[31:0] = {bus.in_instr[31:12], 12'b0};
         FMT_J: newEntry.imm[20:0] = {bus.in_instr[31], bus.in_instr[19:12],
                                      bus.in_instr[20], bus.in_instr[30:21], 1'b0};
         FMT_RAW16: newEntry.imm[15:0] = bus.in_instr[15:0];
         default: begin
            newEntry.imm    = '0;
            newEntry.fmtErr = 1'b1;
         end
      endcase
   end

   assign bus.in_ready    = (count_q != FULL);
   assign bus.out_valid   = (count_q != EMPTY);
   assign bus.out_imm     = head_q.imm;
   assign bus.out_tag     = head_q.tag;
   assign bus.out_fmt_err = head_q.fmtErr;

   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;

   // Flush wins over everything; push+pop at FULL is impossible because in_ready is low.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         count_d = EMPTY;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (count_q == EMPTY) begin
                  head_d  = newEntry;
                  count_d = ONE;
               end else begin
                  tail_d  = newEntry;
                  count_d = FULL;
               end
            end
            2'b01: begin
               head_d  = tail_q;
               count_d = (count_q == FULL) ? ONE : EMPTY;
            end
            2'b11: begin
               head_d = newEntry;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= EMPTY;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: XLEN=32 and XLEN=64 instances driven in lockstep
// and compared against an independent immediate model and a FIFO occupancy model.
module tb_imm_ext_pipe;

   localparam int TAG_W = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic flush = 1'b0;

   always #5 clk = ~clk;

   imm_ext_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) bus32 ();
   imm_ext_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) bus64 ();

   imm_ext_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus32)
   );

   imm_ext_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus64)
   );

   typedef struct {
      logic [63:0]      imm;
      logic [TAG_W-1:0] tag;
      logic             err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic [31:0] dirInstr [11] = '{32'hFFF00093, 32'hFFF00093, 32'hFE112E23, 32'hFE000EE3,
                                  32'h0080006F, 32'h800000B7, 32'h800000B7, 32'h00008000,
                                  32'h00008000, 32'h12345678, 32'hFFFFFFFF};
   logic [2:0]  dirFmt   [11] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd3, 3'd5, 3'd5, 3'd7, 3'd6};
   logic        dirUns   [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   // Build the raw field at its natural width, then sign-extend from its top bit.
   function automatic exp_t expectedImm(input logic [31:0] instr, input logic [2:0] fmt,
                                        input logic uns, input logic [TAG_W-1:0] tag);
      exp_t        e;
      logic [63:0] v;
      int          w;
      v     = '0;
      w     = 0;
      e.err = 1'b0;
      e.tag = tag;
      case (fmt)
         3'd0: begin v = {52'b0, instr[31:20]};                                       w = 12; end
         3'd1: begin v = {52'b0, instr[31:25], instr[11:7]};                          w = 12; end
         3'd2: begin v = {51'b0, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}; w = 13; end
         3'd3: begin v = {32'b0, instr[31:12], 12'b0};                                w = 32; end
         3'd4: begin v = {43'b0, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}; w = 21; end
         3'd5: begin v = {48'b0, instr[15:0]};                                        w = 16; end
         default: e.err = 1'b1;
      endcase
      if (w > 0 && !uns && v[w-1])
         v = v | ~((64'd1 << w) - 64'd1);
      e.imm = v;
      return e;
   endfunction

   task automatic sampleAndModel();
      int   n;
      logic push;
      logic pop;
      n = sb.size();
      checkOutput("in_ready32",  64'(bus32.in_ready),  64'(n != 2));
      checkOutput("in_ready64",  64'(bus64.in_ready),  64'(n != 2));
      checkOutput("out_valid32", 64'(bus32.out_valid), 64'(n != 0));
      checkOutput("out_valid64", 64'(bus64.out_valid), 64'(n != 0));
      if (n != 0) begin
         checkOutput("imm32", 64'(bus32.out_imm),     {32'b0, sb[0].imm[31:0]});
         checkOutput("imm64", bus64.out_imm,          sb[0].imm);
         checkOutput("tag32", 64'(bus32.out_tag),     64'(sb[0].tag));
         checkOutput("tag64", 64'(bus64.out_tag),     64'(sb[0].tag));
         checkOutput("err32", 64'(bus32.out_fmt_err), 64'(sb[0].err));
         checkOutput("err64", 64'(bus64.out_fmt_err), 64'(sb[0].err));
      end
      push = bus64.in_valid && (n != 2) && !flush;
      pop  = (n != 0) && bus64.out_ready && !flush;
      if (flush) begin
         sb.delete();
      end else begin
         if (pop)
            void'(sb.pop_front());
         if (push)
            sb.push_back(expectedImm(bus64.in_instr, bus64.in_fmt, bus64.in_unsigned, bus64.in_tag));
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [2:0] fmt,
                                input logic uns, input logic [TAG_W-1:0] tag,
                                input logic ready, input logic fl);
      bus32.in_valid    = valid;   bus64.in_valid    = valid;
      bus32.in_instr    = instr;   bus64.in_instr    = instr;
      bus32.in_fmt      = fmt;     bus64.in_fmt      = fmt;
      bus32.in_unsigned = uns;     bus64.in_unsigned = uns;
      bus32.in_tag      = tag;     bus64.in_tag      = tag;
      bus32.out_ready   = ready;   bus64.out_ready   = ready;
      flush             = fl;
      #1;
      sampleAndModel();
      @(negedge clk);
   endtask

   task automatic checkResetOutputs(input string phase);
      checkOutput({phase, "_valid32"}, 64'(bus32.out_valid),   64'd0);
      checkOutput({phase, "_valid64"}, 64'(bus64.out_valid),   64'd0);
      checkOutput({phase, "_ready32"}, 64'(bus32.in_ready),    64'd1);
      checkOutput({phase, "_ready64"}, 64'(bus64.in_ready),    64'd1);
      checkOutput({phase, "_imm32"},   64'(bus32.out_imm),     64'd0);
      checkOutput({phase, "_imm64"},   bus64.out_imm,          64'd0);
      checkOutput({phase, "_tag64"},   64'(bus64.out_tag),     64'd0);
      checkOutput({phase, "_err64"},   64'(bus64.out_fmt_err), 64'd0);
   endtask

   initial begin
      bus32.in_valid = 1'b0; bus64.in_valid = 1'b0;
      bus32.in_instr = '0;   bus64.in_instr = '0;
      bus32.in_fmt = '0;     bus64.in_fmt = '0;
      bus32.in_unsigned = 1'b0; bus64.in_unsigned = 1'b0;
      bus32.in_tag = '0;     bus64.in_tag = '0;
      bus32.out_ready = 1'b0; bus64.out_ready = 1'b0;

      #1 rst_n = 1'b0;
      #2 checkResetOutputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Every format back to back with the consumer always ready.
      for (int i = 0; i < 11; i++)
         applyStimulus(1'b1, dirInstr[i], dirFmt[i], dirUns[i], TAG_W'(i + 1), 1'b1, 1'b0);
      repeat (3) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);

      // Stall: tag 3 must be held off until the buffer drains a slot.
      applyStimulus(1'b1, 32'h00100093, 3'd0, 1'b0, 5'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hFFE00093, 3'd0, 1'b0, 5'd2, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h00300093, 3'd0, 1'b0, 5'd3, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h00300093, 3'd0, 1'b0, 5'd3, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h00300093, 3'd0, 1'b0, 5'd3, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h00300093, 3'd0, 1'b0, 5'd3, 1'b1, 1'b0);
      repeat (2) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);

      // Flush while full with a concurrent push, then an illegal format in order.
      applyStimulus(1'b1, 32'h0AB00093, 3'd0, 1'b0, 5'd4, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h8000F0B7, 3'd3, 1'b0, 5'd5, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h00900093, 3'd0, 1'b0, 5'd9, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'hFFFFFFFF, 3'd7, 1'b0, 5'd10, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h7FF00093, 3'd0, 1'b0, 5'd11, 1'b1, 1'b0);
      repeat (3) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);

      for (int i = 0; i < 300; i++)
         applyStimulus($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                       1'($urandom), TAG_W'($urandom), $urandom_range(0, 3) != 0,
                       $urandom_range(0, 31) == 0);

      // Fill the buffer, then drop reset between edges.
      applyStimulus(1'b1, 32'h00100093, 3'd0, 1'b0, 5'd20, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h00200093, 3'd0, 1'b0, 5'd21, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h00300093, 3'd0, 1'b0, 5'd22, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1 checkResetOutputs("async_rst");
      sb.delete();
      @(negedge clk);
      checkResetOutputs("held_rst");
      rst_n = 1'b1;
      applyStimulus(1'b1, 32'hFFF00093, 3'd0, 1'b0, 5'd23, 1'b1, 1'b0);

      for (int i = 0; i < 10 && sb.size() != 0; i++)
         applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
      checkOutput("drain", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
